// File: rtl/mem_access_if.sv
// Bundle between the pipeline MEM stage, the byte-wide synchronous RAM and
// the write-back stage. The master side is whoever drives the memory-op
// inputs and supplies RAM read data; the slave side is mem_access itself.
interface mem_access_if;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        stall_req;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;

  modport master (
    output mem_read, mem_write, mem_wd, mem_wreg, mem_waddr, mem_wdata, ram_din,
    input  ram_addr, ram_we, ram_dout, stall_req, wb_wd, wb_wreg, wb_wdata
  );

  modport slave (
    input  mem_read, mem_write, mem_wd, mem_wreg, mem_waddr, mem_wdata, ram_din,
    output ram_addr, ram_we, ram_dout, stall_req, wb_wd, wb_wreg, wb_wdata
  );
endinterface

// File: rtl/mem_access.sv
// MEM stage that serialises byte/half/word loads and stores onto an 8-bit
// synchronous RAM, one byte per cycle, stalling the pipeline while it works.
// Non-memory ops pass straight through to write-back with no latency.
module mem_access (
  input logic        clk,
  input logic        rst,
  mem_access_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] load_buf;

  logic        is_store;
  logic        is_load;
  logic        is_mem;
  logic [1:0]  last_cnt;
  logic [1:0]  cap_idx;
  logic [4:0]  cap_lo;
  logic [4:0]  out_lo;
  logic [31:0] load_result;

  // Classify the presented op; a nonzero store type overrides any load type.
  always_comb begin
    is_store = (bus.mem_write != 2'd0);
    is_load  = !is_store && (bus.mem_read >= 3'd1) && (bus.mem_read <= 3'd5);
    is_mem   = is_store || is_load;
    last_cnt = 2'd0;
    if (is_store) begin
      case (bus.mem_write)
        2'd2:    last_cnt = 2'd1;
        2'd3:    last_cnt = 2'd3;
        default: last_cnt = 2'd0;
      endcase
    end else begin
      case (bus.mem_read)
        3'd2, 3'd5: last_cnt = 2'd1;
        3'd3:       last_cnt = 2'd3;
        default:    last_cnt = 2'd0;
      endcase
    end
    // Read data lags its address by one cycle, so ACCESS captures the byte
    // issued on the previous cycle and WAIT captures the final byte.
    cap_idx = (state == WAIT) ? last_cnt : (cnt - 2'd1);
    cap_lo  = {cap_idx, 3'b000};
    out_lo  = {cnt, 3'b000};
  end

  // Extend the assembled load buffer according to the load type.
  always_comb begin
    case (bus.mem_read)
      3'd1:    load_result = {{24{load_buf[7]}}, load_buf[7:0]};
      3'd2:    load_result = {{16{load_buf[15]}}, load_buf[15:0]};
      3'd4:    load_result = {24'd0, load_buf[7:0]};
      3'd5:    load_result = {16'd0, load_buf[15:0]};
      default: load_result = load_buf;
    endcase
  end

  // Sequencer: walks the bytes of an access and fills the load buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      load_buf <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            state    <= ACCESS;
            cnt      <= 2'd0;
            load_buf <= 32'd0;
          end
        end
        ACCESS: begin
          if (is_load && (cnt != 2'd0))
            load_buf[cap_lo +: 8] <= bus.ram_din;
          if (cnt == last_cnt) begin
            state <= is_store ? DONE : WAIT;
            cnt   <= 2'd0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        WAIT: begin
          load_buf[cap_lo +: 8] <= bus.ram_din;
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode; reset forces every output to its idle value at once.
  always_comb begin
    bus.stall_req = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_dout  = 8'd0;
    bus.ram_addr  = bus.mem_waddr;
    bus.wb_wd     = 5'd0;
    bus.wb_wreg   = 1'b0;
    bus.wb_wdata  = 32'd0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            bus.stall_req = 1'b1;
          end else begin
            bus.wb_wd    = bus.mem_wd;
            bus.wb_wreg  = bus.mem_wreg;
            bus.wb_wdata = bus.mem_wdata;
          end
        end
        ACCESS: begin
          bus.stall_req = 1'b1;
          bus.ram_addr  = bus.mem_waddr + {30'd0, cnt};
          if (is_store) begin
            bus.ram_we   = 1'b1;
            bus.ram_dout = bus.mem_wdata[out_lo +: 8];
          end
        end
        WAIT: begin
          bus.stall_req = 1'b1;
        end
        default: begin
          bus.wb_wd    = bus.mem_wd;
          bus.wb_wreg  = bus.mem_wreg;
          bus.wb_wdata = is_store ? bus.mem_wdata : load_result;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a table of ops with hand-computed results,
// a byte-wide synchronous RAM model, and hand sequences for wrap and reset.
module tb_mem_access;

  logic clk;
  logic rst;
  mem_access_if bus ();

  mem_access dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_stall;
    int          exp_writes;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [7:0]  ram [0:4095];
  logic [31:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];

  // Synchronous byte RAM: write on we, registered read of the presented address.
  always @(posedge clk) begin
    if (bus.ram_we) begin
      ram[bus.ram_addr[11:0]] <= bus.ram_dout;
      wr_addr_q.push_back(bus.ram_addr);
      wr_data_q.push_back(bus.ram_dout);
    end
    bus.ram_din <= ram[bus.ram_addr[11:0]];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.mem_read  = v.rd;
    bus.mem_write = v.wr;
    bus.mem_wd    = v.wd;
    bus.mem_wreg  = v.wreg;
    bus.mem_waddr = v.addr;
    bus.mem_wdata = v.wdata;
  endtask

  // Called just after a rising edge; presents the op, counts stall cycles,
  // checks the write-back cycle, then advances one cycle past it.
  task automatic apply_stimulus(input vec_t v, input string name);
    int stalls;
    bit done;
    wr_addr_q.delete();
    wr_data_q.delete();
    drive(v);
    stalls = 0;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!bus.stall_req) done = 1;
      else begin
        stalls++;
        @(posedge clk); #1;
      end
    end
    check_output({name, " done"}, {31'd0, done}, 32'd1);
    check_output({name, " stalls"}, stalls, v.exp_stall);
    check_output({name, " wb_wdata"}, bus.wb_wdata, v.exp_data);
    check_output({name, " wb_wd"}, {27'd0, bus.wb_wd}, {27'd0, v.wd});
    check_output({name, " wb_wreg"}, {31'd0, bus.wb_wreg}, {31'd0, v.wreg});
    check_output({name, " ram_addr idle"}, bus.ram_addr, v.addr);
    check_output({name, " ram_dout idle"}, {24'd0, bus.ram_dout}, 32'd0);
    check_output({name, " writes"}, wr_addr_q.size(), v.exp_writes);
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic [2:0] rd, input logic [1:0] wr, input logic [4:0] wd,
                              input logic wreg, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_data, input int exp_stall, input int exp_writes);
    vec_t v;
    v.rd = rd; v.wr = wr; v.wd = wd; v.wreg = wreg; v.addr = addr; v.wdata = wdata;
    v.exp_data = exp_data; v.exp_stall = exp_stall; v.exp_writes = exp_writes;
    return v;
  endfunction

  vec_t vecs [13];
  vec_t sw_a, sh_wrap, sw_rst, lw_rst;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h200] = 8'h80;
    ram[12'h201] = 8'hFF;
    ram[12'h202] = 8'h00;
    ram[12'h203] = 8'h12;

    vecs[0]  = mk(3'd0, 2'd0, 5'd3, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
    vecs[1]  = mk(3'd3, 2'd0, 5'd5, 1'b1, 32'h0000_0200, 32'h0,        32'h1200_FF80, 6, 0);
    vecs[2]  = mk(3'd1, 2'd0, 5'd6, 1'b1, 32'h0000_0200, 32'h0,        32'hFFFF_FF80, 3, 0);
    vecs[3]  = mk(3'd4, 2'd0, 5'd7, 1'b1, 32'h0000_0200, 32'h0,        32'h0000_0080, 3, 0);
    vecs[4]  = mk(3'd2, 2'd0, 5'd8, 1'b1, 32'h0000_0200, 32'h0,        32'hFFFF_FF80, 4, 0);
    vecs[5]  = mk(3'd5, 2'd0, 5'd9, 1'b1, 32'h0000_0200, 32'h0,        32'h0000_FF80, 4, 0);
    vecs[6]  = mk(3'd3, 2'd0, 5'd10, 1'b1, 32'h0000_0200, 32'h0,       32'h1200_FF80, 6, 0);
    vecs[7]  = mk(3'd4, 2'd0, 5'd11, 1'b1, 32'h0000_0203, 32'h0,       32'h0000_0012, 3, 0);
    vecs[8]  = mk(3'd2, 2'd0, 5'd12, 1'b1, 32'h0000_0201, 32'h0,       32'h0000_00FF, 4, 0);
    vecs[9]  = mk(3'd1, 2'd0, 5'd13, 1'b1, 32'h0000_0201, 32'h0,       32'hFFFF_FFFF, 3, 0);
    vecs[10] = mk(3'd3, 2'd1, 5'd14, 1'b0, 32'h0000_0300, 32'h1234_565A, 32'h1234_565A, 2, 1);
    vecs[11] = mk(3'd4, 2'd0, 5'd15, 1'b1, 32'h0000_0300, 32'h0,       32'h0000_005A, 3, 0);
    vecs[12] = mk(3'd6, 2'd0, 5'd16, 1'b1, 32'h0000_0300, 32'hCAFE_0001, 32'hCAFE_0001, 0, 0);

    sw_a    = mk(3'd0, 2'd3, 5'd1, 1'b0, 32'h0000_0100, 32'h1122_3344, 32'h1122_3344, 5, 4);
    sh_wrap = mk(3'd0, 2'd2, 5'd2, 1'b0, 32'hFFFF_FFFF, 32'h0000_ABCD, 32'h0000_ABCD, 3, 2);
    sw_rst  = mk(3'd0, 2'd3, 5'd4, 1'b0, 32'h0000_0400, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 5, 4);
    lw_rst  = mk(3'd3, 2'd0, 5'd17, 1'b1, 32'h0000_0400, 32'h0,       32'hA1B2_C3D4, 6, 0);

    // Reset held with a store presented: outputs must sit at reset values.
    rst = 1'b1;
    bus.ram_din = 8'h00;
    drive(sw_a);
    repeat (2) @(posedge clk);
    #1;
    check_output("reset stall_req", {31'd0, bus.stall_req}, 32'd0);
    check_output("reset ram_we", {31'd0, bus.ram_we}, 32'd0);
    check_output("reset ram_dout", {24'd0, bus.ram_dout}, 32'd0);
    check_output("reset wb_wreg", {31'd0, bus.wb_wreg}, 32'd0);
    check_output("reset wb_wd", {27'd0, bus.wb_wd}, 32'd0);
    check_output("reset wb_wdata", bus.wb_wdata, 32'd0);
    rst = 1'b0;

    // Word store, then its byte stream.
    apply_stimulus(sw_a, "sw 0x100");
    for (int i = 0; i < 4; i++) begin
      if (i < wr_addr_q.size()) begin
        check_output($sformatf("sw byte%0d addr", i), wr_addr_q[i], 32'h100 + i);
        check_output($sformatf("sw byte%0d data", i), {24'd0, wr_data_q[i]}, {24'd0, sw_a.wdata[8*i +: 8]});
      end
    end

    // Table: non-memory op directly followed by LW, then the load/store mix.
    for (int i = 0; i < 13; i++)
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Word store written earlier reads back intact.
    apply_stimulus(mk(3'd3, 2'd0, 5'd18, 1'b1, 32'h100, 32'h0, 32'h1122_3344, 6, 0), "lw 0x100");

    // Halfword store across the top of the address space.
    apply_stimulus(sh_wrap, "sh wrap");
    if (wr_addr_q.size() == 2) begin
      check_output("sh wrap addr0", wr_addr_q[0], 32'hFFFF_FFFF);
      check_output("sh wrap data0", {24'd0, wr_data_q[0]}, 32'h0000_00CD);
      check_output("sh wrap addr1", wr_addr_q[1], 32'h0000_0000);
      check_output("sh wrap data1", {24'd0, wr_data_q[1]}, 32'h0000_00AB);
    end

    // Reset pulsed in the second byte cycle of a word store.
    wr_addr_q.delete();
    wr_data_q.delete();
    drive(sw_rst);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_output("midrst ram_we", {31'd0, bus.ram_we}, 32'd0);
    check_output("midrst stall_req", {31'd0, bus.stall_req}, 32'd0);
    check_output("midrst ram_dout", {24'd0, bus.ram_dout}, 32'd0);
    check_output("midrst wb_wdata", bus.wb_wdata, 32'd0);
    @(posedge clk); #1;
    check_output("midrst writes", wr_addr_q.size(), 1);
    if (wr_addr_q.size() >= 1) begin
      check_output("midrst addr0", wr_addr_q[0], 32'h400);
      check_output("midrst data0", {24'd0, wr_data_q[0]}, 32'h0000_00D4);
    end
    check_output("midrst ram 0x401", {24'd0, ram[12'h401]}, 32'd0);
    rst = 1'b0;
    apply_stimulus(sw_rst, "sw reissue");
    apply_stimulus(lw_rst, "lw 0x400");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
